// File: rtl/palindrome_tx.sv
// Serial palindrome frame transmitter: sends a latched half-word LSB first,
// then its mirror image, with an optional shared middle bit for odd frames.
module palindrome_tx #(
  parameter int HALF_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HALF_W-1:0] data_i,
  input  logic              odd_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              x_o,
  output logic              x_valid_o,
  output logic              last_o,
  output logic              busy_o
);

  localparam int CW = $clog2(HALF_W) + 1;
  localparam int IW = $clog2(HALF_W);
  localparam logic [CW-1:0] TOP_IDX = CW'(HALF_W - 1);
  localparam logic [CW-1:0] MID_IDX = CW'(HALF_W - 2);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    REV
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [HALF_W-1:0] data_q;
  logic [HALF_W-1:0] data_next;
  logic              odd_q;
  logic              odd_next;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic              accept;

  assign accept = valid_i & ready_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      data_q <= '0;
      odd_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_next;
      data_q <= data_next;
      odd_q  <= odd_next;
      cnt    <= cnt_next;
    end
  end

  // The last REV bit can accept the next frame, so frames chain with no bubble.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    data_next  = data_q;
    odd_next   = odd_q;
    if (accept) begin
      data_next = data_i;
      odd_next  = odd_i;
    end
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = FWD;
          cnt_next   = '0;
        end
      end
      FWD: begin
        if (cnt == TOP_IDX) begin
          state_next = REV;
          cnt_next   = odd_q ? MID_IDX : TOP_IDX;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      REV: begin
        if (cnt == '0) begin
          if (accept) begin
            state_next = FWD;
            cnt_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ready_o is forced low while reset is held, even though state is IDLE.
  always_comb begin
    busy_o    = 1'b0;
    x_valid_o = 1'b0;
    x_o       = 1'b0;
    last_o    = 1'b0;
    ready_o   = 1'b0;
    if (state != IDLE) begin
      busy_o    = 1'b1;
      x_valid_o = 1'b1;
      x_o       = data_q[cnt[IW-1:0]];
    end
    if ((state == REV) && (cnt == '0)) begin
      last_o = 1'b1;
    end
    ready_o = ~reset & ((state == IDLE) | last_o);
  end

endmodule

// File: tb/tb_palindrome_tx.sv
// Self-checking bench for palindrome_tx: a scoreboard queue of expected
// {last, bit} pairs is filled when frames are offered and drained by a monitor.
module tb_palindrome_tx;

  logic       clk;
  logic       reset;
  logic [3:0] data_i;
  logic       odd_i;
  logic       valid_i;
  logic       ready_o;
  logic       x_o;
  logic       x_valid_o;
  logic       last_o;
  logic       busy_o;

  logic [1:0] data2_i;
  logic       odd2_i;
  logic       valid2_i;
  logic       ready2_o;
  logic       x2_o;
  logic       x_valid2_o;
  logic       last2_o;
  logic       busy2_o;

  int         checks;
  int         fails;
  logic [1:0] exp_q[$];

  palindrome_tx #(.HALF_W(4)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .data_i    (data_i),
    .odd_i     (odd_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .x_o       (x_o),
    .x_valid_o (x_valid_o),
    .last_o    (last_o),
    .busy_o    (busy_o)
  );

  palindrome_tx #(.HALF_W(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .data_i    (data2_i),
    .odd_i     (odd2_i),
    .valid_i   (valid2_i),
    .ready_o   (ready2_o),
    .x_o       (x2_o),
    .x_valid_o (x_valid2_o),
    .last_o    (last2_o),
    .busy_o    (busy2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected frame built from the half-word in bench terms, not from the DUT.
  task automatic push_frame(input logic [3:0] d, input logic odd);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, d[i]});
    for (int i = (odd ? 2 : 3); i >= 0; i--) exp_q.push_back({(i == 0), d[i]});
  endtask

  // Scoreboard monitor: every valid serial bit must match the next queued bit.
  always @(negedge clk) begin
    if (!reset && x_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL scoreboard_extra: got x_o=%0b last_o=%0b, expected no bit", x_o, last_o);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({last_o, x_o} !== e) begin
          fails++;
          $display("[TB] FAIL scoreboard_bit: got last_o=%0b x_o=%0b, expected last_o=%0b x_o=%0b",
                   last_o, x_o, e[1], e[0]);
        end
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    #2;
    checks++;
    if ({x_o, x_valid_o, last_o, busy_o, ready_o} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %05b, expected 00000", {x_o, x_valid_o, last_o, busy_o, ready_o});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_release: got ready_o=%0b busy_o=%0b, expected 1 0", ready_o, busy_o);
    end
  endtask

  // Drives one isolated frame and checks strobes cycle by cycle.
  task automatic test_single(input logic [3:0] d, input logic odd, input string name);
    int n;
    n = odd ? 7 : 8;
    data_i  = d;
    odd_i   = odd;
    valid_i = 1'b1;
    push_frame(d, odd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) valid_i = 1'b0;
      checks++;
      if (x_valid_o !== 1'b1 || busy_o !== 1'b1 || last_o !== (i == n - 1) || ready_o !== (i == n - 1)) begin
        fails++;
        $display("[TB] FAIL %s_strobes cycle %0d: got valid=%0b busy=%0b last=%0b ready=%0b, expected 1 1 %0b %0b",
                 name, i + 1, x_valid_o, busy_o, last_o, ready_o, (i == n - 1), (i == n - 1));
      end
    end
    @(negedge clk);
    checks++;
    if (x_valid_o !== 1'b0 || x_o !== 1'b0 || ready_o !== 1'b1 || exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s_idle: got valid=%0b x=%0b ready=%0b pending=%0d, expected 0 0 1 0",
               name, x_valid_o, x_o, ready_o, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    data_i  = 4'b1011;
    odd_i   = 1'b0;
    valid_i = 1'b1;
    push_frame(4'b1011, 1'b0);
    push_frame(4'b0001, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 0) begin
        data_i = 4'b0001;
        odd_i  = 1'b1;
      end
      if (i == 8) valid_i = 1'b0;
      checks++;
      if (x_valid_o !== 1'b1 || ready_o !== (i == 7 || i == 14) || last_o !== (i == 7 || i == 14)) begin
        fails++;
        $display("[TB] FAIL b2b_strobes cycle %0d: got valid=%0b ready=%0b last=%0b, expected 1 %0b %0b",
                 i + 1, x_valid_o, ready_o, last_o, (i == 7 || i == 14), (i == 7 || i == 14));
      end
    end
    @(negedge clk);
    checks++;
    if (x_valid_o !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL b2b_end: got valid=%0b pending=%0d, expected 0 0", x_valid_o, exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    data_i  = 4'b0101;
    odd_i   = 1'b0;
    valid_i = 1'b1;
    push_frame(4'b0101, 1'b0);
    push_frame(4'b1111, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        valid_i = 1'b0;
        data_i  = 4'b0000;
      end
      if (i == 3) begin
        valid_i = 1'b1;
        data_i  = 4'b1111;
      end
      if (i == 8) begin
        valid_i = 1'b0;
        data_i  = 4'b0000;
      end
      checks++;
      if (x_valid_o !== 1'b1 || ready_o !== (i == 7 || i == 15)) begin
        fails++;
        $display("[TB] FAIL backpressure_ready cycle %0d: got valid=%0b ready=%0b, expected 1 %0b",
                 i + 1, x_valid_o, ready_o, (i == 7 || i == 15));
      end
    end
    @(negedge clk);
    checks++;
    if (x_valid_o !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL backpressure_end: got valid=%0b pending=%0d, expected 0 0", x_valid_o, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    data_i  = 4'b1001;
    odd_i   = 1'b0;
    valid_i = 1'b1;
    push_frame(4'b1001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) valid_i = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    checks++;
    if ({x_valid_o, busy_o, ready_o, x_o, last_o} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset_abort: got valid=%0b busy=%0b ready=%0b x=%0b last=%0b, expected all 0",
               x_valid_o, busy_o, ready_o, x_o, last_o);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || x_valid_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_restart: got ready=%0b busy=%0b valid=%0b, expected 1 0 0", ready_o, busy_o, x_valid_o);
    end
    test_single(4'b0011, 1'b1, "post_reset_odd");
  endtask

  // Narrowest width: 3-bit odd frame checked by a 3-bit palindrome detector.
  task automatic test_half_w2;
    logic [2:0] sr;
    logic [2:0] exp_bits;
    exp_bits = 3'b010;
    sr       = '0;
    data2_i  = 2'b10;
    odd2_i   = 1'b1;
    valid2_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) valid2_i = 1'b0;
      sr = {sr[1:0], x2_o};
      checks++;
      if (x_valid2_o !== 1'b1 || x2_o !== exp_bits[2 - i] || last2_o !== (i == 2)) begin
        fails++;
        $display("[TB] FAIL w2_bit %0d: got valid=%0b x=%0b last=%0b, expected 1 %0b %0b",
                 i + 1, x_valid2_o, x2_o, last2_o, exp_bits[2 - i], (i == 2));
      end
    end
    checks++;
    if (sr[2] !== sr[0]) begin
      fails++;
      $display("[TB] FAIL w2_palindrome: got frame %03b, expected a palindrome", sr);
    end
    @(negedge clk);
    checks++;
    if (x_valid2_o !== 1'b0 || ready2_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL w2_idle: got valid=%0b ready=%0b, expected 0 1", x_valid2_o, ready2_o);
    end
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    reset    = 1'b1;
    data_i   = '0;
    odd_i    = 1'b0;
    valid_i  = 1'b0;
    data2_i  = '0;
    odd2_i   = 1'b0;
    valid2_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_single(4'b0110, 1'b0, "even");
    test_single(4'b0110, 1'b1, "odd");
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_half_w2();
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/palindrome_tx.md
Name: palindrome_tx

Overview:
Serial transmitter that builds palindromic bit frames for the team's serial palindrome-checking receivers.
- Accepts a HALF_W-bit half-word over a valid/ready handshake.
- Emits the half-word one bit per cycle, LSB first, then its mirror image, so every frame reads the same in both directions.
- Supports even-length (2*HALF_W) and odd-length (2*HALF_W-1, shared middle bit) frames.
- Sits on the stimulus/transmit side of the serial link, driving x_o with a qualifying strobe.

Parameters:
HALF_W, 4, half-word width in bits; legal range 2..16.

Ports:
clk  input  1  clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
data_i  input  HALF_W  half-word to transmit.
odd_i  input  1  1 = odd-length frame (middle bit sent once), 0 = even-length frame.
valid_i  input  1  data_i/odd_i valid.
ready_o  output  1  block can accept a new half-word this cycle.
x_o  output  1  serial data bit.
x_valid_o  output  1  x_o carries a frame bit this cycle.
last_o  output  1  current bit is the final bit of the frame.
busy_o  output  1  frame in progress.

Behaviour:
- Clock and reset: clk is the clock. reset is asynchronous, active-high.
- Reset values: state=IDLE; internal data register 0; odd flag 0; bit counter 0. While reset is high, outputs are x_o=0, x_valid_o=0, last_o=0, busy_o=0, ready_o=0.
- States:
  - IDLE: no frame active.
  - FWD: sending bits 0..HALF_W-1, counter increments.
  - REV: sending mirror bits, counter decrements.
- Counter: width $clog2(HALF_W)+1, no wrap. Counts 0..HALF_W-1 in FWD and down to 0 in REV.
- Handshake:
  - Accept when valid_i & ready_o on a rising edge; data_i and odd_i are latched.
  - ready_o = (state==IDLE) | last_o, gated off while reset is high.
  - valid_i with ready_o=0 is ignored; data_i is not sampled. The sender must hold valid_i until accepted.
- Latency: accept on edge k; first bit (data bit 0) drives x_o with x_valid_o=1 in the cycle after edge k.
- IDLE -> FWD on accept; counter=0.
- FWD: x_o = data[cnt].
  - At cnt==HALF_W-1, go to REV.
  - Even mode: next REV counter = HALF_W-1.
  - Odd mode: next REV counter = HALF_W-2, so the middle bit is not repeated.
- REV: x_o = data[cnt]. At cnt==0, last_o=1.
  - If an accept occurs on that edge, go to FWD with counter=0: back-to-back frames, no idle bubble.
  - Otherwise go to IDLE.
- Frame bit order:
  - Even: d0..d(W-1), d(W-1)..d0.
  - Odd: d0..d(W-1), d(W-2)..d0.
- x_valid_o = busy_o = (state != IDLE). x_o=0 whenever x_valid_o=0.
- Latched data and mode are stable for the whole frame; changes on data_i or odd_i mid-frame have no effect.
- Reset mid-frame: frame aborted immediately (asynchronous). No partial bits after reset deasserts; the block restarts in IDLE.
- No flow control on the serial side: the receiver must consume one bit per cycle.

Test Plan:
- HALF_W=4, data_i=4'b0110, odd_i=0, single accept -> x_o over 8 cycles = 0,1,1,0,0,1,1,0; x_valid_o high for exactly 8 cycles; last_o only on cycle 8; ready_o low on cycles 1-7.
- HALF_W=4, data_i=4'b0110, odd_i=1 -> 7 bits 0,1,1,0,1,1,0; last_o on cycle 7; bit 3 appears once.
- Back-to-back: valid_i held high with 4'b1011 even, then 4'b0001 odd accepted on the last_o cycle -> 1,1,0,1,1,0,1,1 then 1,0,0,0,0,0,1 with no gap; x_valid_o continuous for 15 cycles.
- Backpressure: valid_i asserted with data 4'b1111 during an active frame -> not accepted until the last_o cycle; data_i changed mid-frame to 4'b0000 does not alter the current frame's bits.
- Reset asserted on cycle 3 of an even 4'b1001 frame -> x_valid_o, busy_o, ready_o drop to 0 immediately. After deassert: IDLE, ready_o=1, and a new 4'b0011 odd frame is sent correctly: 1,1,0,0,0,1,1.
- HALF_W=2, odd_i=1, data 2'b10 -> 3-bit frame 0,1,0. Check with a 3-bit palindrome checker on x_o: flagged palindrome on the third bit.
